// File: rtl/lfi_sweep_scheduler.sv
// lfi_sweep_scheduler: shares one Lfi datapath across NUM_NEURONS neurons per sweep; LFI_REFRACTORY_EN adds refractory skipping
module lfi_sweep_scheduler #(
  parameter int NUM_NEURONS    = 4,
  parameter int ID_W           = 2,
  parameter int DATA_W         = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int REFRACT_SWEEPS = 2
) (
  input  logic                          clk_i,
  input  logic                          reset,
  input  logic                          tick_i,
  input  logic [NUM_NEURONS*DATA_W-1:0] current_i,
  output logic                          dp_valid_o,
  input  logic                          dp_ready_i,
  output logic [DATA_W-1:0]             dp_state_o,
  output logic [DATA_W-1:0]             dp_current_o,
  input  logic                          dp_resp_valid_i,
  input  logic [DATA_W-1:0]             dp_state_i,
  input  logic                          dp_spike_i,
  output logic                          spike_valid_o,
  output logic [ID_W-1:0]               spike_id_o,
  input  logic                          spike_ready_i,
  output logic                          busy_o,
  output logic                          sweep_done_o,
  output logic                          overrun_o,
  output logic                          drop_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [1:0]        st;
  logic [ID_W-1:0]   idx;
  logic [DATA_W-1:0] mem  [NUM_NEURONS];
  logic [DATA_W-1:0] snap [NUM_NEURONS];
  logic [ID_W-1:0]   fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic skip, resp, adv, last, push, pop, full, push_ok;
`ifdef LFI_REFRACTORY_EN
  localparam int R_W = $clog2(REFRACT_SWEEPS + 1);
  logic [R_W-1:0] refr [NUM_NEURONS];
  assign skip = (st == ISSUE) && (refr[idx] != '0);
  // refractory counters: load on a spike, count down on each skipped visit
  always_ff @(posedge clk_i or posedge reset)
    if (reset)
      for (int k = 0; k < NUM_NEURONS; k++) refr[k] <= '0;
    else if (skip)
      refr[idx] <= refr[idx] - 1'b1;
    else if (push)
      refr[idx] <= R_W'(REFRACT_SWEEPS);
`else
  logic unused_refr;
  assign skip        = 1'b0;
  assign unused_refr = REFRACT_SWEEPS != 0;
`endif
  assign resp          = (st == WAIT) && dp_resp_valid_i;
  assign adv           = resp || skip;
  assign last          = idx == ID_W'(NUM_NEURONS - 1);
  assign busy_o        = st != IDLE;
  assign dp_valid_o    = (st == ISSUE) && !skip;
  assign dp_state_o    = (st == ISSUE) ? mem[idx] : '0;
  assign dp_current_o  = (st == ISSUE) ? snap[idx] : '0;
  assign sweep_done_o  = adv && last;
  assign overrun_o     = tick_i && busy_o;
  assign push          = resp && dp_spike_i;
  assign spike_valid_o = cnt != '0;
  assign spike_id_o    = spike_valid_o ? fifo[rd_ptr] : '0;
  assign pop           = spike_valid_o && spike_ready_i;
  assign full          = cnt == CNT_W'(FIFO_DEPTH);
  assign push_ok       = push && (!full || pop);
  // sweep sequencing, snapshot at tick and membrane write-back
  always_ff @(posedge clk_i or posedge reset)
    if (reset) begin
      st  <= IDLE;
      idx <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        mem[k]  <= '0;
        snap[k] <= '0;
      end
    end else begin
      if (st == IDLE && tick_i) begin
        st  <= ISSUE;
        idx <= '0;
        for (int k = 0; k < NUM_NEURONS; k++) snap[k] <= current_i[k*DATA_W +: DATA_W];
      end else if (dp_valid_o && dp_ready_i)
        st <= WAIT;
      if (adv) begin
        mem[idx] <= skip ? '0 : dp_state_i;
        st       <= last ? IDLE : ISSUE;
        idx      <= last ? '0 : idx + 1'b1;
      end
    end
  // spike FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge clk_i or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      drop_o <= 1'b0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      cnt    <= cnt + CNT_W'(push_ok) - CNT_W'(pop);
      drop_o <= drop_o || (push && !push_ok);
    end
  // spike FIFO storage; a full push with a pop overwrites the slot being read out
  always_ff @(posedge clk_i)
    if (push_ok) fifo[wr_ptr] <= idx;
endmodule

// File: tb/tb_lfi_sweep_scheduler.sv
// tb_lfi_sweep_scheduler: directed and randomized sweeps checked against a behavioural neuron/FIFO model
module tb_lfi_sweep_scheduler;
  logic        clk_i = 1'b0, reset = 1'b1, tick_i = 1'b0;
  logic [31:0] current_i = '0;
  logic        dp_valid_o, dp_ready_i = 1'b0;
  logic [7:0]  dp_state_o, dp_current_o, dp_state_i = '0;
  logic        dp_resp_valid_i = 1'b0, dp_spike_i = 1'b0;
  logic        spike_valid_o, spike_ready_i = 1'b0;
  logic [1:0]  spike_id_o;
  logic        busy_o, sweep_done_o, overrun_o, drop_o;
  int n_tests = 0, n_fail = 0;
  logic [7:0] ref_state [4];
  int  q[$];
  bit  ref_drop;

  lfi_sweep_scheduler dut (
    .clk_i(clk_i), .reset(reset), .tick_i(tick_i), .current_i(current_i),
    .dp_valid_o(dp_valid_o), .dp_ready_i(dp_ready_i), .dp_state_o(dp_state_o),
    .dp_current_o(dp_current_o), .dp_resp_valid_i(dp_resp_valid_i),
    .dp_state_i(dp_state_i), .dp_spike_i(dp_spike_i), .spike_valid_o(spike_valid_o),
    .spike_id_o(spike_id_o), .spike_ready_i(spike_ready_i), .busy_o(busy_o),
    .sweep_done_o(sweep_done_o), .overrun_o(overrun_o), .drop_o(drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) ref_state[k] = '0;
    q.delete();
    ref_drop = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, dp_valid_o, 0);
    chk({tag, "_dstate"}, dp_state_o, 0);
    chk({tag, "_dcur"}, dp_current_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_svalid"}, spike_valid_o, 0);
    chk({tag, "_sid"}, spike_id_o, 0);
    chk({tag, "_done"}, sweep_done_o, 0);
    chk({tag, "_ovr"}, overrun_o, 0);
    chk({tag, "_drop"}, drop_o, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    chk_all_zero("rst");
    model_reset();
    @(negedge clk_i);
    reset = 1'b0;
  endtask

  task automatic drain();
    while (q.size() > 0) begin
      chk("pop_valid", spike_valid_o, 1);
      chk("pop_id", spike_id_o, q[0]);
      spike_ready_i = 1'b1;
      @(negedge clk_i);
      spike_ready_i = 1'b0;
      void'(q.pop_front());
    end
    chk("drained", spike_valid_o, 0);
  endtask

  task automatic do_sweep(input logic [31:0] cur, input logic [3:0] mask, input logic [3:0] popm,
                          input int stall, input bit ovr, input int abort_at);
    logic [7:0] c [4];
    for (int k = 0; k < 4; k++) c[k] = cur[k*8 +: 8];
    tick_i = 1'b1;
    current_i = cur;
    @(negedge clk_i);
    tick_i = 1'b0;
    current_i = $urandom;
    chk("busy_start", busy_o, 1);
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < stall; s++) begin
        dp_ready_i = 1'b0;
        dp_resp_valid_i = 1'b1;
        dp_spike_i = 1'b1;
        dp_state_i = 8'($urandom);
        tick_i = ovr && k == 1 && s == 0;
        #1;
        chk("stall_valid", dp_valid_o, 1);
        chk("stall_state", dp_state_o, ref_state[k]);
        chk("stall_cur", dp_current_o, c[k]);
        chk("stall_busy", busy_o, 1);
        chk("overrun", overrun_o, ovr && k == 1 && s == 0);
        @(negedge clk_i);
      end
      tick_i = 1'b0;
      dp_resp_valid_i = 1'b0;
      dp_spike_i = 1'b0;
      dp_ready_i = 1'b1;
      #1;
      chk("issue_valid", dp_valid_o, 1);
      chk("issue_state", dp_state_o, ref_state[k]);
      chk("issue_cur", dp_current_o, c[k]);
      chk("issue_done", sweep_done_o, 0);
      @(negedge clk_i);
      dp_ready_i = 1'b0;
      #1;
      chk("wait_valid", dp_valid_o, 0);
      chk("wait_busy", busy_o, 1);
      if (k == abort_at) begin
        pulse_reset();
        return;
      end
      dp_resp_valid_i = 1'b1;
      dp_state_i = ref_state[k] + c[k];
      dp_spike_i = mask[k];
      spike_ready_i = popm[k];
      #1;
      chk("done", sweep_done_o, k == 3);
      chk("fifo_valid", spike_valid_o, q.size() > 0);
      if (popm[k] && q.size() > 0) begin
        chk("fifo_head", spike_id_o, q[0]);
        void'(q.pop_front());
      end
      if (mask[k]) begin
        if (q.size() < 4) q.push_back(k);
        else ref_drop = 1;
      end
      @(negedge clk_i);
      ref_state[k] = dp_state_i;
      dp_resp_valid_i = 1'b0;
      dp_spike_i = 1'b0;
      spike_ready_i = 1'b0;
    end
    #1;
    chk("busy_end", busy_o, 0);
    chk("done_end", sweep_done_o, 0);
    chk("drop", drop_o, ref_drop);
    chk("end_svalid", spike_valid_o, q.size() > 0);
    if (q.size() > 0) chk("end_sid", spike_id_o, q[0]);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_i);
    chk_all_zero("init");
    reset = 1'b0;
    @(negedge clk_i);
    do_sweep(32'h04030201, 4'b0000, 4'b0000, 0, 0, -1);
    do_sweep(32'h04030201, 4'b1010, 4'b0000, 0, 0, -1);
    drain();
    do_sweep($urandom, 4'b0000, 4'b0000, 5, 1, -1);
    do_sweep($urandom, 4'b1111, 4'b0000, 0, 0, -1);
    do_sweep($urandom, 4'b1111, 4'b0000, 0, 0, -1);
    chk("drop_set", drop_o, 1);
    drain();
    pulse_reset();
    do_sweep($urandom, 4'b1111, 4'b0000, 0, 0, -1);
    do_sweep($urandom, 4'b0001, 4'b0001, 0, 0, -1);
    chk("no_drop", drop_o, 0);
    drain();
    do_sweep($urandom, 4'($urandom), 4'b0000, 1, 0, -1);
    do_sweep($urandom, 4'($urandom), 4'b0000, 0, 0, 2);
    do_sweep($urandom, 4'b0000, 4'b0000, 0, 0, -1);
    for (int i = 0; i < 10; i++) begin
      int st;
      st = $urandom_range(0, 2);
      do_sweep($urandom, 4'($urandom), 4'($urandom), st, st > 0 && $urandom_range(0, 1) == 1, -1);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lfi_sweep_scheduler.md
Name: lfi_sweep_scheduler

Overview:
Time-multiplexes one shared Lfi neuron datapath across NUM_NEURONS virtual neurons. On each sweep tick it walks the neurons in index order, issues each stored membrane state plus its input current to the datapath, writes back the result, and queues the indices of neurons that fired into a spike FIFO. It sits between the chip-level input/current registers and the single Lfi compute core.

Parameters:
NUM_NEURONS, 4, number of virtual neurons (2..16)
ID_W, 2, neuron index width; equals clog2(NUM_NEURONS)
DATA_W, 8, width of current and membrane state
FIFO_DEPTH, 4, spike FIFO entries (power of 2, >=2)
REFRACT_SWEEPS, 2, refractory length in sweeps; used only when LFI_REFRACTORY_EN is defined

Ports:
clk_i  in  1  clock
reset  in  1  asynchronous active-high reset
tick_i  in  1  one-cycle pulse: start one sweep
current_i  in  NUM_NEURONS*DATA_W  per-neuron current; neuron k at bits [k*DATA_W +: DATA_W]
dp_valid_o  out  1  request to datapath valid
dp_ready_i  in  1  datapath accepts request
dp_state_o  out  DATA_W  membrane state sent to datapath
dp_current_o  out  DATA_W  current sent to datapath
dp_resp_valid_i  in  1  datapath result valid (one-cycle pulse)
dp_state_i  in  DATA_W  updated membrane state
dp_spike_i  in  1  neuron fired (qualified by dp_resp_valid_i)
spike_valid_o  out  1  spike FIFO not empty
spike_id_o  out  ID_W  index of oldest queued spike
spike_ready_i  in  1  consumer pops spike
busy_o  out  1  sweep in progress
sweep_done_o  out  1  one-cycle pulse when last neuron written back
overrun_o  out  1  one-cycle pulse: tick_i received while busy
drop_o  out  1  sticky: spike lost on full FIFO; cleared only by reset

Behaviour:
- Reset (async, reset=1): FSM=IDLE, idx=0, all membrane states=0, current snapshot=0, FIFO empty; all outputs 0.
- Datapath handshake: a request transfers when dp_valid_o & dp_ready_i are both 1. dp_valid_o, dp_state_o and dp_current_o hold stable until then. Only one request is outstanding at a time.
- FSM states:
  - IDLE: busy_o=0. On tick_i: snapshot all of current_i, idx<=0, go ISSUE.
  - ISSUE: dp_valid_o=1, dp_state_o=state[idx], dp_current_o=snapshot[idx]. On handshake, go WAIT next cycle.
  - WAIT: dp_valid_o=0. On dp_resp_valid_i:
    - state[idx]<=dp_state_i.
    - If dp_spike_i, push idx into the FIFO.
    - If idx==NUM_NEURONS-1: pulse sweep_done_o, go IDLE.
    - Otherwise idx<=idx+1, go ISSUE.
  - dp_resp_valid_i outside WAIT is ignored.
- Minimum latency: 2 cycles per neuron (ISSUE with ready=1, then response in the next WAIT cycle). A 4-neuron sweep therefore takes at least 8 cycles after the tick.
- busy_o=1 in ISSUE and WAIT.
- tick_i while busy: tick ignored, overrun_o pulses for 1 cycle, sweep continues unaffected.
- current_i changes during a sweep have no effect, because the snapshot is taken at the tick.
- Spike FIFO:
  - spike_valid_o = !empty; spike_id_o = head entry; pop on spike_valid_o & spike_ready_i.
  - Push when full and no pop that cycle: the entry is discarded and drop_o is set.
  - Push when full with a pop in the same cycle: the push succeeds and occupancy is unchanged.
  - Simultaneous push and pop when empty: the entry is stored and spike_valid_o rises the next cycle. There is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter distinguishes full from empty.
- Reset mid-sweep aborts the sweep immediately. Partial state write-backs are cleared to 0.

Optional Feature:
LFI_REFRACTORY_EN
- Defined:
  - Each neuron has a counter of width clog2(REFRACT_SWEEPS+1), reset to 0.
  - When a neuron spikes, its counter is loaded with REFRACT_SWEEPS.
  - In ISSUE, if refr[idx]!=0: no datapath request is issued; state[idx]<=0; refr[idx] decrements; idx advances (or the sweep completes) after 1 cycle.
- Undefined: no counters exist and every neuron is issued every sweep.

Test Plan:
- Reset, then tick_i with current_i=0x04_03_02_01 and the datapath model returning state+current, no spike: after 8 cycles (ready=1) sweep_done_o pulses; a second sweep shows dp_state_o = 1,2,3,4.
- Datapath model asserts spike for neurons 1 and 3, spike_ready_i=0: spike_valid_o=1 and spike_id_o=1; one pop gives 3; a second pop leaves spike_valid_o=0.
- Hold dp_ready_i=0 for 5 cycles in ISSUE: dp_valid_o and dp_state_o stay stable; busy_o=1; a tick_i during this window gives overrun_o=1 for one cycle, and the sweep still ends after neuron 3.
- FIFO_DEPTH=4, all neurons spike for 2 sweeps, no pops: 4 entries 0,1,2,3 retained and drop_o=1. Repeat with spike_ready_i=1 on the full cycle: no drop.
- Assert reset while in WAIT at idx=2: all outputs 0 at once; the next sweep issues state 0 for every neuron.
- With LFI_REFRACTORY_EN and REFRACT_SWEEPS=2, neuron 0 spikes in sweep 1: sweeps 2 and 3 skip neuron 0 (no dp_valid_o for idx 0), and sweep 4 issues it with state 0.
